// File: rtl/serial_loader_module.sv
// serial_loader_module: debounced push-button loader that captures a switch
// word on each clean press and shifts it out one bit per slow tick.
// Optional build macro SERIAL_LOADER_LSB_FIRST_EN: shift the word out LSB
// first instead of the default MSB first.
module serial_loader_module #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 4194304,
    parameter int DEBOUNCE = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_btn,
    input  logic [WIDTH-1:0] data_in,
    output logic             serial_out,
    output logic             shift_tick,
    output logic             busy,
    output logic             done
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);
    localparam int unsigned BW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             btn_db_q, btn_db_d;
    logic             btn_dly_q, btn_dly_d;
    logic [DW-1:0]    db_cnt_q, db_cnt_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             shift_tick_q, shift_tick_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             start;
    logic [WIDTH-1:0] shreg_next;
    logic             out_bit;

    // Synchronize the raw button and accept a new level only after DEBOUNCE stable cycles
    always_comb begin
        sync1_d   = load_btn;
        sync2_d   = sync1_q;
        btn_db_d  = btn_db_q;
        btn_dly_d = btn_db_q;
        db_cnt_d  = '0;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DW'(DEBOUNCE - 1)) begin
                btn_db_d = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        start = btn_db_q & ~btn_dly_q;
    end

    // Shift-word FSM; outputs are derived from next state so they come out registered
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        tick_cnt_d = tick_cnt_q;
`ifdef SERIAL_LOADER_LSB_FIRST_EN
        shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
`else
        shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SHIFT;
                    shreg_d    = data_in;
                    bit_cnt_d  = '0;
                    tick_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
                    tick_cnt_d = '0;
                    shreg_d    = shreg_next;
                    if (bit_cnt_q == BW'(WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef SERIAL_LOADER_LSB_FIRST_EN
        out_bit = shreg_d[0];
`else
        out_bit = shreg_d[WIDTH-1];
`endif
        busy_d       = (state_d == ST_SHIFT);
        done_d       = (state_d == ST_DONE);
        serial_out_d = (state_d == ST_SHIFT) & out_bit;
        shift_tick_d = (state_d == ST_SHIFT) && (tick_cnt_d == TW'(TICK_DIV - 1));
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            btn_db_q     <= 1'b0;
            btn_dly_q    <= 1'b0;
            db_cnt_q     <= '0;
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            serial_out_q <= 1'b0;
            shift_tick_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            btn_db_q     <= btn_db_d;
            btn_dly_q    <= btn_dly_d;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            serial_out_q <= serial_out_d;
            shift_tick_q <= shift_tick_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign serial_out = serial_out_q;
    assign shift_tick = shift_tick_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
